// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two WIDTH-bit operands one nibble per cycle through an
// external 4-bit ripple-carry adder, LSB nibble first, with valid/ready on both sides.
// Optional subtract mode: define NIBBLE_SERIAL_ADDER_SUB_EN to add the in_sub port.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout,
    output logic             busy
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic [WIDTH-1:0] a_sh, b_sh, b_in;
    logic             carry_reg, cin_in, last, accept, run;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1; the forced carry-in replaces in_cin.
    assign b_in   = in_sub ? ~in_b : in_b;
    assign cin_in = in_sub | in_cin;
`else
    assign b_in   = in_b;
    assign cin_in = in_cin;
`endif

    assign run       = state == RUN;
    assign last      = k == KW'(N - 1);
    assign in_ready  = rst_n && state == IDLE;
    assign accept    = in_valid && in_ready;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_sum   = out_valid ? sum_reg : '0;
    assign out_cout  = out_valid & carry_reg;
    assign a_sh      = a_reg >> {k, 2'b00};
    assign b_sh      = b_reg >> {k, 2'b00};
    assign add_a     = run ? a_sh[3:0] : 4'h0;
    assign add_b     = run ? b_sh[3:0] : 4'h0;
    assign add_cin   = run & carry_reg;

    // Next-state logic: accept in IDLE, step through N nibbles, hold until the output handshake.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Datapath: latch operands on accept, then capture one sum nibble and the carry per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
        end else if (accept) begin
            a_reg     <= in_a;
            b_reg     <= b_in;
            carry_reg <= cin_in;
            k         <= '0;
        end else if (run) begin
            sum_reg[{k, 2'b00} +: 4] <= add_s;
            carry_reg                <= add_cout;
            k                        <= k + 1'b1;
        end
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequencer that adds two WIDTH-bit operands by streaming 4-bit slices through an external 4-bit ripple-carry adder, least-significant nibble first.
- Sits directly around the 4-bit adder. It drives the adder's a, b and carry-in, consumes its sum and final carry-out, and rebuilds the full-width result.
- Upstream and downstream use valid/ready handshakes.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and at least 4. N = WIDTH/4 nibble steps.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands are presented.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry into nibble 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  sum.
- out_cout  output  1  carry out of the MSB nibble.
- add_a  output  4  A nibble to the external adder.
- add_b  output  4  B nibble to the external adder.
- add_cin  output  1  carry-in to the external adder.
- add_s  input  4  sum nibble from the external adder (combinational).
- add_cout  input  1  MSB carry-out from the external adder (combinational).
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Nibble index k is a counter of width clog2(N) with a minimum of 1 bit.
- Reset (rst_n low, async):
  - state = IDLE, k = 0.
  - Operand, sum and carry registers cleared.
  - out_valid = 0, out_sum = 0, out_cout = 0, busy = 0.
  - add_a = 0, add_b = 0, add_cin = 0.
  - in_ready is forced to 0 while rst_n is low.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_a, in_b, in_cin into a_reg, b_reg, carry_reg; k = 0; go to RUN.
- RUN:
  - add_a = a_reg[4k+3:4k], add_b = b_reg[4k+3:4k], add_cin = carry_reg, all driven from registers only.
  - Each edge: sum_reg[4k+3:4k] <= add_s; carry_reg <= add_cout; k <= k+1.
  - After capturing nibble N-1: go to DONE, out_valid <= 1.
  - in_ready = 0; in_valid is ignored.
- DONE:
  - out_sum = sum_reg, out_cout = carry_reg, both held stable while out_valid is high.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - No bypass: a new operand can be accepted only from the cycle after the output handshake.
- Adder drive outside RUN: add_a, add_b and add_cin are driven to 0 in IDLE and DONE.
- Latency and throughput:
  - out_valid rises exactly N cycles after the accepting edge.
  - Minimum initiation interval is N+2 cycles.
- Arithmetic: result is (in_a + in_b + in_cin) mod 2^WIDTH, with out_cout as bit WIDTH.
- Boundaries:
  - WIDTH=4: a single RUN cycle.
  - Carry propagates across every nibble, e.g. all-ones + 1.
  - out_ready held low indefinitely: stay in DONE, outputs frozen.
  - out_ready high in the same cycle out_valid rises: the handshake completes on the next edge.
  - rst_n asserted mid-RUN or in DONE: the operation is discarded with no partial output; the block returns to IDLE.
  - X on in_a or in_b while in_valid is low must not propagate into the registers.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port in_sub (1 bit), latched at accept.
  - When in_sub = 1: b_reg latches ~in_b, carry_reg latches 1 (in_cin ignored).
  - out_sum = in_a - in_b mod 2^WIDTH; out_cout = 1 means no borrow.
- Undefined: in_sub port absent; addition only.

Test Plan:
- 0x1234 + 0x4321, cin 0 -> out_sum 0x5555, out_cout 0; out_valid exactly 4 cycles after accept; add_a sequence 4,3,2,1.
- 0xFFFF + 0x0001, cin 0 -> out_sum 0x0000, out_cout 1; add_cin sequence 0,1,1,1.
- 0xFFFF + 0x0000, cin 1 -> out_sum 0x0000, out_cout 1.
- Backpressure: 0x00F0 + 0x0010 with out_ready low for 5 cycles -> out_sum 0x0100 held stable, in_ready 0, a concurrent in_valid not accepted; accepted one cycle after the out handshake.
- Reset pulse after 2 RUN cycles -> all outputs 0, state IDLE; next op 0x0001 + 0x0002 -> 0x0003, cout 0.
- NIBBLE_SERIAL_ADDER_SUB_EN: 0x0005 - 0x0007 with in_sub=1 -> out_sum 0xFFFE, out_cout 0; 0x0007 - 0x0005 -> 0x0002, cout 1.
